// File: rtl/gen_fast_pkg.sv
// Shared definitions for the fast capture (write) and fast packet read paths.
// Holds the bank/address/data geometry, the per-mode bank counts, the one-hot
// FSM state encoding and a helper that maps the path mode onto its last bank.
package gen_fast_pkg;

    localparam int unsigned NUM_BANK = 24;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned DATA_W   = 18;
    localparam int unsigned BANK_W   = 5;

    // Banks in use for the 96-path and 48-path capture modes.
    localparam int unsigned BANKS_96 = 24;
    localparam int unsigned BANKS_48 = 12;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StWrite = 4'b0010,
        StDone  = 4'b0100,
        StRead  = 4'b1000
    } fast_state_e;

    function automatic logic [BANK_W-1:0] last_bank(input logic path96);
        return path96 ? BANK_W'(BANKS_96 - 1) : BANK_W'(BANKS_48 - 1);
    endfunction

endpackage

// File: rtl/gen_write_logic_fast_if.sv
// Capture-path bus between the ADC/config/read-logic side and the fast write
// logic.
//   master : drives config, start, ADC samples and read-done; observes strobes
//   slave  : the write logic (opposite directions)
// Signals:
//   rf_96path_en, rf_wr_depth   capture configuration
//   fast_wr_start               single-cycle capture request
//   adc_data, adc_data_valid    sample stream
//   fast_wr_chip_en/addr/data   one-hot bank write strobe with row and data
//   fast_wr_busy, fast_wr_done  capture status
//   fast_read_en, fast_rd_done  buffer handoff to and from the read logic
interface gen_write_logic_fast_if;
    import gen_fast_pkg::*;

    logic                rf_96path_en;
    logic [ADDR_W-1:0]   rf_wr_depth;
    logic                fast_wr_start;
    logic [DATA_W-1:0]   adc_data;
    logic                adc_data_valid;
    logic [NUM_BANK-1:0] fast_wr_chip_en;
    logic [ADDR_W-1:0]   fast_wr_addr;
    logic [DATA_W-1:0]   fast_wr_data;
    logic                fast_wr_busy;
    logic                fast_wr_done;
    logic                fast_read_en;
    logic                fast_rd_done;

    modport master (
        output rf_96path_en, rf_wr_depth, fast_wr_start, adc_data, adc_data_valid,
               fast_rd_done,
        input  fast_wr_chip_en, fast_wr_addr, fast_wr_data, fast_wr_busy, fast_wr_done,
               fast_read_en
    );

    modport slave (
        input  rf_96path_en, rf_wr_depth, fast_wr_start, adc_data, adc_data_valid,
               fast_rd_done,
        output fast_wr_chip_en, fast_wr_addr, fast_wr_data, fast_wr_busy, fast_wr_done,
               fast_read_en
    );

endinterface

// File: rtl/fast_bank_row_ctr.sv
// Round-robin bank pointer plus row counter for the capture sweep.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   clr_i          return to bank 0, row 0
//   adv_i          step to the next bank (row steps on bank wrap)
//   last_bank_i    highest bank index in the current mode
//   depth_i        last row index of the capture
//   bank_o, row_o  current bank and row
//   final_o        current position is the last write of the capture
module fast_bank_row_ctr
    import gen_fast_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [BANK_W-1:0] last_bank_i,
    input  logic [ADDR_W-1:0] depth_i,
    output logic [BANK_W-1:0] bank_o,
    output logic [ADDR_W-1:0] row_o,
    output logic              final_o
);

    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              wrap;

    assign wrap    = (bank_q == last_bank_i);
    assign final_o = wrap && (row_q == depth_i);
    assign bank_o  = bank_q;
    assign row_o   = row_q;

    always_comb begin
        bank_d = bank_q;
        row_d  = row_q;
        if (clr_i) begin
            bank_d = '0;
            row_d  = '0;
        end else if (adv_i) begin
            if (wrap) begin
                bank_d = '0;
                // Hold the row on the final write so it never runs past depth.
                if (!final_o) begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                bank_d = bank_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q <= '0;
            row_q  <= '0;
        end else begin
            bank_q <= bank_d;
            row_q  <= row_d;
        end
    end

endmodule

// File: rtl/gen_write_logic_fast.sv
// Fast capture write logic: writes the ADC sample stream round-robin into the
// capture SRAM banks, one bank per accepted sample, then hands the filled
// buffer to the fast read logic and waits for it to come back.
// Ports:
//   clk, rstn  capture clock, asynchronous active-low reset
//   bus        gen_write_logic_fast_if slave: config, start, samples,
//              registered bank strobes/status, read handoff
module gen_write_logic_fast
    import gen_fast_pkg::*;
(
    input logic                   clk,
    input logic                   rstn,
    gen_write_logic_fast_if.slave bus
);

    fast_state_e         state_q, state_d;
    logic                path96_q, path96_d;
    logic [ADDR_W-1:0]   depth_q, depth_d;
    logic [NUM_BANK-1:0] chip_en_q, chip_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                read_en_q, read_en_d;

    logic                ctr_clr;
    logic                ctr_adv;
    logic [BANK_W-1:0]   bank;
    logic [ADDR_W-1:0]   row;
    logic                ctr_final;

    fast_bank_row_ctr u_ctr (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (ctr_clr),
        .adv_i       (ctr_adv),
        .last_bank_i (last_bank(path96_q)),
        .depth_i     (depth_q),
        .bank_o      (bank),
        .row_o       (row),
        .final_o     (ctr_final)
    );

    always_comb begin
        state_d   = state_q;
        path96_d  = path96_q;
        depth_d   = depth_q;
        chip_en_d = '0;
        addr_d    = '0;
        data_d    = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        read_en_d = 1'b0;
        ctr_clr   = 1'b0;
        ctr_adv   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.fast_wr_start) begin
                    // Config is sampled once here and frozen for the capture.
                    path96_d = bus.rf_96path_en;
                    depth_d  = bus.rf_wr_depth;
                    ctr_clr  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                busy_d = 1'b1;
                if (bus.adc_data_valid) begin
                    ctr_adv   = 1'b1;
                    chip_en_d = NUM_BANK'(1) << bank;
                    addr_d    = row;
                    data_d    = bus.adc_data;
                    if (ctr_final) begin
                        busy_d  = 1'b0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done_d    = 1'b1;
                read_en_d = 1'b1;
                state_d   = StRead;
            end
            StRead: begin
                read_en_d = 1'b1;
                if (bus.fast_rd_done) begin
                    read_en_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            path96_q  <= 1'b0;
            depth_q   <= '0;
            chip_en_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            read_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            path96_q  <= path96_d;
            depth_q   <= depth_d;
            chip_en_q <= chip_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            read_en_q <= read_en_d;
        end
    end

    assign bus.fast_wr_chip_en = chip_en_q;
    assign bus.fast_wr_addr    = addr_q;
    assign bus.fast_wr_data    = data_q;
    assign bus.fast_wr_busy    = busy_q;
    assign bus.fast_wr_done    = done_q;
    assign bus.fast_read_en    = read_en_q;

endmodule

// File: tb/tb_gen_write_logic_fast.sv
// Directed bench for gen_write_logic_fast: captures in both path modes,
// gapped valids, ignored control inputs, config changes mid-capture, buffer
// handback and an asynchronous reset in the middle of a capture.
module tb_gen_write_logic_fast;
    import gen_fast_pkg::*;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    gen_write_logic_fast_if bus ();

    gen_write_logic_fast dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are registered: look at them 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full capture; expected strobes come from a bank/row model of the sweep.
    task automatic capture(input logic p96, input int depth, input bit gap, input bit poke,
                           input int depth_change_at);
        int   nb;
        int   total;
        int   k;
        logic v;
        nb    = p96 ? 24 : 12;
        total = (depth + 1) * nb;
        k     = 0;
        bus.rf_96path_en  = p96;
        bus.rf_wr_depth   = depth[ADDR_W-1:0];
        bus.fast_wr_start = 1'b1;
        step();
        bus.fast_wr_start = 1'b0;
        chk("start_busy", bus.fast_wr_busy, 1);
        chk("start_no_strobe", bus.fast_wr_chip_en, 0);
        for (int c = 0; k < total && c < 2000; c++) begin
            v = gap ? (c % 2 == 0) : 1'b1;
            bus.adc_data_valid = v;
            bus.adc_data       = DATA_W'(k);
            if (poke) begin
                bus.fast_wr_start = c[0];
                bus.fast_rd_done  = ~c[0];
            end
            if (c == depth_change_at) begin
                bus.rf_wr_depth  = '0;
                bus.rf_96path_en = ~p96;
            end
            step();
            if (v) begin
                chk("strobe", bus.fast_wr_chip_en, 32'(24'(1) << (k % nb)));
                chk("addr", bus.fast_wr_addr, k / nb);
                chk("data", bus.fast_wr_data, k);
                k++;
                chk("busy", bus.fast_wr_busy, k < total);
                chk("no_early_done", bus.fast_wr_done, 0);
            end else begin
                chk("gap_strobe", bus.fast_wr_chip_en, 0);
            end
        end
        bus.adc_data_valid = 1'b0;
        bus.fast_wr_start  = 1'b0;
        bus.fast_rd_done   = 1'b0;
        step();
        chk("done_pulse", bus.fast_wr_done, 1);
        chk("read_en_rise", bus.fast_read_en, 1);
        chk("busy_low", bus.fast_wr_busy, 0);
        chk("done_idle_strobe", bus.fast_wr_chip_en, 0);
        step();
        chk("done_single", bus.fast_wr_done, 0);
        chk("read_en_hold", bus.fast_read_en, 1);
    endtask

    // Ignored start/valid in READ, then return the buffer.
    task automatic handback();
        bus.fast_wr_start  = 1'b1;
        bus.adc_data_valid = 1'b1;
        step();
        chk("read_ignore_start", bus.fast_wr_busy, 0);
        chk("read_ignore_valid", bus.fast_wr_chip_en, 0);
        chk("read_en_kept", bus.fast_read_en, 1);
        bus.fast_wr_start  = 1'b0;
        bus.adc_data_valid = 1'b0;
        bus.fast_rd_done   = 1'b1;
        step();
        bus.fast_rd_done = 1'b0;
        chk("read_en_drop", bus.fast_read_en, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn               = 1'b0;
        bus.rf_96path_en   = 1'b0;
        bus.rf_wr_depth    = '0;
        bus.fast_wr_start  = 1'b0;
        bus.adc_data       = '0;
        bus.adc_data_valid = 1'b0;
        bus.fast_rd_done   = 1'b0;
        #12;
        chk("rst_chip_en", bus.fast_wr_chip_en, 0);
        chk("rst_addr", bus.fast_wr_addr, 0);
        chk("rst_data", bus.fast_wr_data, 0);
        chk("rst_busy", bus.fast_wr_busy, 0);
        chk("rst_done", bus.fast_wr_done, 0);
        chk("rst_read_en", bus.fast_read_en, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Rd_done outside READ must not disturb IDLE.
        bus.fast_rd_done = 1'b1;
        step();
        bus.fast_rd_done = 1'b0;
        chk("idle_rd_done", bus.fast_wr_busy, 0);

        capture(1'b1, 0, 1'b0, 1'b0, -1);
        handback();
        // Start issued the cycle after handback.
        capture(1'b0, 2, 1'b0, 1'b0, -1);
        handback();
        capture(1'b1, 1, 1'b1, 1'b1, -1);
        handback();
        // Depth 3 -> 0 and mode flip mid-capture: still four 24-bank rows.
        capture(1'b1, 3, 1'b0, 1'b0, 10);
        handback();

        // Asynchronous reset in the middle of a capture.
        bus.rf_96path_en  = 1'b1;
        bus.rf_wr_depth   = 15'd5;
        bus.fast_wr_start = 1'b1;
        step();
        bus.fast_wr_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.adc_data_valid = 1'b1;
            bus.adc_data       = DATA_W'(i);
            step();
        end
        chk("pre_rst_strobe", bus.fast_wr_chip_en, 32'h10);
        chk("pre_rst_data", bus.fast_wr_data, 4);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_chip_en", bus.fast_wr_chip_en, 0);
        chk("arst_data", bus.fast_wr_data, 0);
        chk("arst_busy", bus.fast_wr_busy, 0);
        chk("arst_read_en", bus.fast_read_en, 0);
        bus.adc_data_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        capture(1'b1, 0, 1'b0, 1'b0, -1);
        handback();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
